pc_ras_unit: RTL and testbench
==============================

# pc_ras_unit

Parametrised program-counter and redirect unit for the 5-stage pipelined processor's fetch stage. It owns the fetch PC, applies taken-branch, BAL and BR redirects resolved in decode, and generates the one-cycle fetch/decode squash. It replaces the single return-address register with a return-address stack of configurable depth that reports overflow and underflow. It also holds the pipeline-wide halt latch.

## Interface
- PC_W, 16: PC and target width.
- ADDR_W, 12: instruction-memory address width; ADDR_W <= PC_W.
- DISP_W, 8: branch displacement width, sign-extended to PC_W.
- RAS_DEPTH, 4: return-address stack entries; power of two, >= 2.
- RESET_PC, 0: PC value after reset.
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  load-use hazard; freezes PC, flush, RAS and halt evaluation.
- dec_pc  in  PC_W  PC of the instruction currently in decode.
- dec_disp  in  DISP_W  displacement field of the decode instruction.
- dec_br_taken  in  1  decode holds B, or a conditional branch whose condition is true.
- dec_bal  in  1  decode holds BAL.
- dec_br  in  1  decode holds BR (return).
- dec_halt  in  1  decode holds HLT.
- pc  out  PC_W  current fetch PC.
- imem_addr  out  ADDR_W  pc[ADDR_W-1:0], combinational.
- flush  out  1  squashes the fetch and decode slots; registered.
- halting  out  1  sticky halt; registered.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid stack entries.
- ras_overflow  out  1  sticky; a push discarded the oldest entry.
- ras_underflow  out  1  sticky; BR executed with an empty stack.

## Operation
- Reset values: pc=RESET_PC, flush=0, halting=0, ras_count=0, ras_overflow=0, ras_underflow=0, all stack entries 0.
- target = dec_pc + sign_ext(dec_disp), computed modulo 2^PC_W. Return address = dec_pc + 1, also modulo 2^PC_W.
- While halting=1, all state is frozen and every input is ignored. Only reset clears halting.
- While stall=1, all state holds, including flush.
- If flush=1 and stall=0, the decode slot is a squashed bubble. All dec_* inputs are ignored, and the unit does pc <= pc+1, flush <= 0.
- Otherwise the first matching row applies, in this order:
  - dec_br with ras_count>0: pop; pc <= top entry; ras_count decrements; flush <= 1.
  - dec_br with ras_count=0: pc holds; ras_underflow <= 1; halting <= 1; flush <= 0.
  - dec_bal: push (dec_pc+1); pc <= target; flush <= 1. If the stack is full, the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_overflow <= 1.
  - dec_br_taken: pc <= target; flush <= 1.
  - dec_halt: halting <= 1; pc holds; flush <= 0.
  - No match: pc <= pc+1; flush <= 0.
- Stack organisation: circular buffer with a top pointer. Pop returns the most recent push (LIFO). A pop after an overflow returns the newest RAS_DEPTH entries, in reverse order of pushing.

## Timing
- Redirect latency: if the decode instruction causes a redirect at edge N, pc=target after edge N and flush=1 for exactly one cycle after edge N.
- Stalls: a stall asserted in the flush cycle extends that flush cycle until stall drops.
- Halt latency: halting rises at the edge after HLT is evaluated. The PC does not advance past the HLT fetch address + 1.
- Reset: asserting reset_n=0 at any time, including mid-flush or mid-stall, forces reset values immediately, with no clock edge required. The unit resumes on the first rising edge after release.
- Combinational paths: imem_addr is the only combinational output. There is no combinational path from dec_* or stall to any output.

## Test plan
- Sequential fetch: reset with RESET_PC=0, hold all dec_* low for 5 cycles -> pc steps 0,1,2,3,4,5; flush=0; imem_addr tracks pc.
- Backward branch: dec_pc=0x0010, dec_disp=0xFC, dec_br_taken=1 -> pc=0x000C next cycle and flush=1 for one cycle. Set dec_br_taken=1 during that flush cycle -> ignored; pc=0x000D.
- Nested calls: issue BAL from dec_pc 0x20, 0x40, 0x60, then BR three times -> returns to 0x61, 0x41, 0x21; ras_count goes 3,2,1,0; no flags set.
- Overflow and underflow (RAS_DEPTH=4): issue 5 BALs -> ras_overflow=1, ras_count=4. Then 4 BRs return the newest 4 addresses. A fifth BR -> ras_underflow=1, halting=1, and pc frozen.
- Stall interaction: assert stall together with dec_bal -> pc, flush and ras_count unchanged while stall=1. On release the BAL takes effect exactly once.
- Halt and async reset: assert dec_halt -> halting=1 and pc frozen for 10 cycles. Drive reset_n low between clock edges -> pc=RESET_PC and halting=0 immediately.

Source files
------------

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch PC, decode-resolved redirects, return-address stack and halt latch
//
// Ports:
//   clock, reset_n        : sole clock; asynchronous active-low reset
//   stall                 : load-use hazard, freezes every piece of state
//   dec_pc, dec_disp      : PC and displacement of the instruction in decode
//   dec_br_taken, dec_bal,
//   dec_br, dec_halt      : decoded control-flow class of that instruction
//   pc, imem_addr         : fetch PC (registered) and its low address bits (combinational)
//   flush                 : registered one-cycle squash of fetch and decode slots
//   halting               : sticky halt, cleared only by reset
//   ras_count             : valid return-stack entries
//   ras_overflow/underflow: sticky stack error flags
module pc_ras_unit #(
  parameter int PC_W      = 16,
  parameter int ADDR_W    = 12,
  parameter int DISP_W    = 8,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic [PC_W-1:0]              dec_pc,
  input  logic [DISP_W-1:0]            dec_disp,
  input  logic                         dec_br_taken,
  input  logic                         dec_bal,
  input  logic                         dec_br,
  input  logic                         dec_halt,
  output logic [PC_W-1:0]              pc,
  output logic [ADDR_W-1:0]            imem_addr,
  output logic                         flush,
  output logic                         halting,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q;
  logic             flush_q;
  logic             halting_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  // top_q is the next slot to write; the newest entry sits at top_q-1.
  // Pushing onto a full stack simply wraps and overwrites the oldest slot.
  logic [PTR_W-1:0] top_q;

  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  ret_addr;
  logic [PC_W-1:0]  pc_inc;
  logic [PTR_W-1:0] top_idx;

  assign target   = dec_pc + PC_W'($signed(dec_disp));
  assign ret_addr = dec_pc + PC_W'(1);
  assign pc_inc   = pc_q + PC_W'(1);
  assign top_idx  = top_q - PTR_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      flush_q   <= 1'b0;
      halting_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      top_q     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (!halting_q && !stall) begin
      if (flush_q) begin
        // decode slot holds a squashed bubble
        pc_q    <= pc_inc;
        flush_q <= 1'b0;
      end else if (dec_br) begin
        if (cnt_q != '0) begin
          pc_q    <= stack_q[top_idx];
          top_q   <= top_idx;
          cnt_q   <= cnt_q - CNT_W'(1);
          flush_q <= 1'b1;
        end else begin
          unf_q     <= 1'b1;
          halting_q <= 1'b1;
          flush_q   <= 1'b0;
        end
      end else if (dec_bal) begin
        stack_q[top_q] <= ret_addr;
        top_q          <= top_q + PTR_W'(1);
        if (cnt_q == CNT_FULL) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        pc_q    <= target;
        flush_q <= 1'b1;
      end else if (dec_br_taken) begin
        pc_q    <= target;
        flush_q <= 1'b1;
      end else if (dec_halt) begin
        halting_q <= 1'b1;
        flush_q   <= 1'b0;
      end else begin
        pc_q    <= pc_inc;
        flush_q <= 1'b0;
      end
    end
  end

  assign pc            = pc_q;
  assign imem_addr     = pc_q[ADDR_W-1:0];
  assign flush         = flush_q;
  assign halting       = halting_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - randomized self-checking bench for pc_ras_unit against a queue-based model
module tb_pc_ras_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [15:0] dec_pc;
  logic [7:0]  dec_disp;
  logic        dec_br_taken;
  logic        dec_bal;
  logic        dec_br;
  logic        dec_halt;
  logic [15:0] pc;
  logic [11:0] imem_addr;
  logic        flush;
  logic        halting;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic        m_flush;
  logic        m_halt;
  logic        m_ovf;
  logic        m_unf;
  logic [15:0] m_stk[$];

  pc_ras_unit #(
    .PC_W(16), .ADDR_W(12), .DISP_W(8), .RAS_DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .dec_pc(dec_pc), .dec_disp(dec_disp), .dec_br_taken(dec_br_taken),
    .dec_bal(dec_bal), .dec_br(dec_br), .dec_halt(dec_halt),
    .pc(pc), .imem_addr(imem_addr), .flush(flush), .halting(halting),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_flush = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // One clock edge of architectural behaviour, from the current inputs.
  task automatic model_step();
    if (m_halt || stall) return;
    if (m_flush) begin
      m_pc = m_pc + 16'd1; m_flush = 0;
    end else if (dec_br) begin
      if (m_stk.size() > 0) begin
        m_pc = m_stk.pop_back(); m_flush = 1;
      end else begin
        m_unf = 1; m_halt = 1; m_flush = 0;
      end
    end else if (dec_bal) begin
      m_stk.push_back(dec_pc + 16'd1);
      if (m_stk.size() > DEPTH) begin
        void'(m_stk.pop_front());
        m_ovf = 1;
      end
      m_pc = 16'(int'(dec_pc) + int'($signed(dec_disp)));
      m_flush = 1;
    end else if (dec_br_taken) begin
      m_pc = 16'(int'(dec_pc) + int'($signed(dec_disp)));
      m_flush = 1;
    end else if (dec_halt) begin
      m_halt = 1; m_flush = 0;
    end else begin
      m_pc = m_pc + 16'd1; m_flush = 0;
    end
  endtask

  task automatic compare_all();
    logic [15:0] mp;
    mp = m_pc;
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, mp[11:0]);
    check("flush", flush, m_flush);
    check("halting", halting, m_halt);
    check("ras_count", ras_count, m_stk.size());
    check("ras_overflow", ras_overflow, m_ovf);
    check("ras_underflow", ras_underflow, m_unf);
  endtask

  task automatic cyc(input logic s, input logic tk, input logic bl, input logic b,
                     input logic h, input logic [15:0] dp, input logic [7:0] dd);
    stall = s; dec_br_taken = tk; dec_bal = bl; dec_br = b; dec_halt = h;
    dec_pc = dp; dec_disp = dd;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 16'h0, 8'h0);
  endtask

  // Reset asserted between edges; outputs must change with no clock edge.
  task automatic do_reset();
    #2;
    reset_n = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clock);
    reset_n = 1;
  endtask

  logic [15:0] frozen_pc;
  int          halted_cycles;

  initial begin
    reset_n = 0; stall = 0; dec_pc = 0; dec_disp = 0;
    dec_br_taken = 0; dec_bal = 0; dec_br = 0; dec_halt = 0;
    model_reset();
    #3;
    compare_all();
    check("reset_pc", pc, 16'h0000);
    @(negedge clock);
    reset_n = 1;

    // sequential fetch
    for (int i = 1; i <= 5; i++) begin
      idle();
      check("seq_pc", pc, i);
    end

    // backward branch, then a taken branch inside the flush cycle is ignored
    cyc(0, 1, 0, 0, 0, 16'h0010, 8'hFC);
    check("bb_pc", pc, 16'h000C);
    check("bb_flush", flush, 1);
    cyc(0, 1, 0, 0, 0, 16'h0010, 8'hFC);
    check("bb_squash_pc", pc, 16'h000D);
    check("bb_squash_flush", flush, 0);

    // nested calls and returns
    cyc(0, 0, 1, 0, 0, 16'h0020, 8'h10); idle();
    cyc(0, 0, 1, 0, 0, 16'h0040, 8'h10); idle();
    cyc(0, 0, 1, 0, 0, 16'h0060, 8'h10); idle();
    check("nest_cnt", ras_count, 3);
    cyc(0, 0, 0, 1, 0, 16'h0000, 8'h00);
    check("ret1", pc, 16'h0061); idle();
    cyc(0, 0, 0, 1, 0, 16'h0000, 8'h00);
    check("ret2", pc, 16'h0041); idle();
    cyc(0, 0, 0, 1, 0, 16'h0000, 8'h00);
    check("ret3", pc, 16'h0021);
    check("nest_cnt0", ras_count, 0);
    check("nest_flags", {ras_overflow, ras_underflow}, 0);
    idle();

    // overflow, newest four returned, then underflow halts
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 1, 0, 0, 16'(i * 16'h0100), 8'h04); idle();
    end
    check("ovf_flag", ras_overflow, 1);
    check("ovf_cnt", ras_count, 4);
    for (int i = 5; i >= 2; i--) begin
      cyc(0, 0, 0, 1, 0, 16'h0, 8'h0);
      check("ovf_ret", pc, 16'(i * 16'h0100 + 1)); idle();
    end
    cyc(0, 0, 0, 1, 0, 16'h0, 8'h0);
    check("unf_flag", ras_underflow, 1);
    check("unf_halt", halting, 1);
    frozen_pc = 16'h0201 + 16'd1;
    for (int i = 0; i < 4; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 0, 16'($urandom), 8'($urandom));
      check("unf_frozen", pc, frozen_pc);
    end
    do_reset();

    // stall together with BAL, and a stall extending the flush cycle
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0, 0, 16'h0030, 8'h10);
      check("stall_pc", pc, 16'h0000);
      check("stall_cnt", ras_count, 0);
    end
    cyc(0, 0, 1, 0, 0, 16'h0030, 8'h10);
    check("stall_rel_pc", pc, 16'h0040);
    check("stall_rel_cnt", ras_count, 1);
    cyc(1, 0, 1, 0, 0, 16'h0030, 8'h10);
    check("stall_flush_hold", flush, 1);
    cyc(0, 0, 1, 0, 0, 16'h0030, 8'h10);
    check("bal_once_cnt", ras_count, 1);
    check("bal_once_pc", pc, 16'h0041);

    // halt, frozen for 10 cycles, then asynchronous reset
    cyc(0, 0, 0, 0, 1, 16'h0041, 8'h00);
    check("halt_set", halting, 1);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("halt_frozen", pc, 16'h0041);
    end
    do_reset();
    check("areset_pc", pc, 16'h0000);
    check("areset_halt", halting, 0);

    // randomized traffic
    halted_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 2, 16'($urandom), 8'($urandom));
      if (m_halt) halted_cycles++;
      if (halted_cycles > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
